// File: rtl/aes_round_sched.sv
// aes_round_sched: shares one AES round core between the two AES_R evaluations
// of a SNOW-V FSM update, with a watchdog on the core's ready handshake.
module aes_round_sched #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [127:0] cmd_blk_a,
  input  logic [127:0] cmd_blk_b,
  input  logic [127:0] cmd_key,
  output logic         round_start,
  output logic [127:0] round_block_i,
  output logic [127:0] round_key,
  input  logic [127:0] round_block_o,
  input  logic         round_ready,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_a,
  output logic [127:0] res_b,
  output logic         err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_A,
    ST_WAIT_A,
    ST_START_B,
    ST_WAIT_B,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);
  localparam logic [7:0] WD_MAX   = 8'hff;

  state_t       state_q, state_d;
  logic [127:0] blk_a_q, blk_a_d;
  logic [127:0] blk_b_q, blk_b_d;
  logic [127:0] key_q, key_d;
  logic [127:0] res_a_q, res_a_d;
  logic [127:0] res_b_q, res_b_d;
  logic [127:0] round_block_q, round_block_d;
  logic [7:0]   wd_q, wd_d;
  logic         cmd_ready_q, cmd_ready_d;
  logic         res_valid_q, res_valid_d;
  logic         err_q, err_d;
  logic         cmd_fire;
  logic         in_wait;
  logic         sel_a_d, sel_b_d;

  assign cmd_fire = cmd_valid && cmd_ready_q;
  assign in_wait  = (state_q == ST_WAIT_A) || (state_q == ST_WAIT_B);

  always_comb begin
    state_d = state_q;
    blk_a_d = blk_a_q;
    blk_b_d = blk_b_q;
    key_d   = key_q;
    res_a_d = res_a_q;
    res_b_d = res_b_q;
    wd_d    = wd_q;

    // Idle-cycle counting is shared by both wait states; a capture overrides it.
    if (in_wait && !round_ready && (wd_q != WD_MAX)) begin
      wd_d = wd_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          blk_a_d = cmd_blk_a;
          blk_b_d = cmd_blk_b;
          key_d   = cmd_key;
          state_d = ST_START_A;
        end
      end
      ST_START_A: begin
        if (round_ready) begin
          wd_d    = '0;
          state_d = ST_WAIT_A;
        end
      end
      ST_WAIT_A: begin
        if (round_ready) begin
          res_a_d = round_block_o;
          state_d = ST_START_B;
        end else if (wd_q == WD_LIMIT) begin
          state_d = ST_ERR;
        end
      end
      ST_START_B: begin
        if (round_ready) begin
          wd_d    = '0;
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (round_ready) begin
          res_b_d = round_block_o;
          state_d = ST_DONE;
        end else if (wd_q == WD_LIMIT) begin
          state_d = ST_ERR;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    res_valid_d = (state_d == ST_DONE);
    err_d       = (state_d == ST_ERR);
  end

  assign sel_a_d = (state_d == ST_START_A) || (state_d == ST_WAIT_A);
  assign sel_b_d = (state_d == ST_START_B) || (state_d == ST_WAIT_B);

  // Core block input is registered from the next state so it is already
  // stable in the START cycle and stays put through the whole wait.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_blk_mux
      assign round_block_d[32*gi +: 32] = sel_a_d ? blk_a_d[32*gi +: 32] :
                                          sel_b_d ? blk_b_d[32*gi +: 32] :
                                                    32'h0;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      blk_a_q       <= '0;
      blk_b_q       <= '0;
      key_q         <= '0;
      res_a_q       <= '0;
      res_b_q       <= '0;
      round_block_q <= '0;
      wd_q          <= '0;
      cmd_ready_q   <= 1'b1;
      res_valid_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      blk_a_q       <= blk_a_d;
      blk_b_q       <= blk_b_d;
      key_q         <= key_d;
      res_a_q       <= res_a_d;
      res_b_q       <= res_b_d;
      round_block_q <= round_block_d;
      wd_q          <= wd_d;
      cmd_ready_q   <= cmd_ready_d;
      res_valid_q   <= res_valid_d;
      err_q         <= err_d;
    end
  end

  // Start follows ready so a core busy with another master just stalls us.
  assign round_start   = ((state_q == ST_START_A) || (state_q == ST_START_B)) && round_ready;
  assign cmd_ready     = cmd_ready_q;
  assign round_block_i = round_block_q;
  assign round_key     = key_q;
  assign res_valid     = res_valid_q;
  assign res_a         = res_a_q;
  assign res_b         = res_b_q;
  assign err           = err_q;

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched with a behavioural AES round core attached:
// latency, back-pressure, stalls, watchdog, async reset and input isolation.
module tb_aes_round_sched;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [127:0] cmd_blk_a = '0;
  logic [127:0] cmd_blk_b = '0;
  logic [127:0] cmd_key = '0;
  logic         round_start;
  logic [127:0] round_block_i;
  logic [127:0] round_key;
  logic [127:0] round_block_o;
  logic         round_ready;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [127:0] res_a;
  logic [127:0] res_b;
  logic         err;

  int total = 0;
  int bad = 0;

  logic         force_busy = 1'b0;
  logic         hang_mode = 1'b0;
  logic [2:0]   core_cnt;
  logic         core_hung;
  logic [127:0] core_blk;
  logic [127:0] core_key;
  int           hold_viol = 0;

  localparam logic [127:0] AES_R_ZERO = 128'h63636363636363636363636363636363;

  always #5 clk = ~clk;

  aes_round_sched #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_blk_a(cmd_blk_a), .cmd_blk_b(cmd_blk_b), .cmd_key(cmd_key),
    .round_start(round_start), .round_block_i(round_block_i), .round_key(round_key),
    .round_block_o(round_block_o), .round_ready(round_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_a(res_a), .res_b(res_b), .err(err)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from first principles: GF(2^8) inverse (x^254) then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] blk, input logic [127:0] key);
    logic [7:0]   st [16];
    logic [7:0]   sr [16];
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int i = 0; i < 16; i++) st[i] = sbox(blk[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[4*c+r] = st[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
      o[127-32*c -: 8]  = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
      o[119-32*c -: 8]  = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
      o[111-32*c -: 8]  = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
      o[103-32*c -: 8]  = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
    end
    return o ^ key;
  endfunction

  // Round core: start at s, ready low s+1..s+5, result and ready at s+6.
  assign round_ready = (core_cnt == 3'd0) && !core_hung && !force_busy;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_cnt      <= '0;
      core_hung     <= 1'b0;
      core_blk      <= '0;
      core_key      <= '0;
      round_block_o <= '0;
    end else if (core_cnt != 3'd0) begin
      core_cnt <= core_cnt - 3'd1;
      if (round_block_i !== core_blk || round_key !== core_key) hold_viol <= hold_viol + 1;
      if (core_cnt == 3'd1) round_block_o <= aes_round(core_blk, core_key);
    end else if (round_start && round_ready) begin
      core_cnt <= 3'd5;
      core_blk <= round_block_i;
      core_key <= round_key;
      if (hang_mode) core_hung <= 1'b1;
    end
  end

  task automatic start_job(input logic [127:0] a, input logic [127:0] b, input logic [127:0] k);
    cmd_blk_a = a;
    cmd_blk_b = b;
    cmd_key   = k;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Called in the first cycle after the handshake (n=1); returns at res_valid.
  task automatic wait_res(input bit scramble, output int lat, output int s1, output int s2,
                          output int nst, output logic [127:0] seen_a, output logic [127:0] seen_b);
    lat = -1; s1 = -1; s2 = -1; nst = 0; seen_a = 'x; seen_b = 'x;
    for (int n = 1; n <= 100; n++) begin
      if (round_start) begin
        nst++;
        if (nst == 1) s1 = n;
        else if (nst == 2) s2 = n;
      end
      if (n == 2) seen_a = round_block_i;
      if (n == 9) seen_b = round_block_i;
      if (res_valid) begin
        lat = n;
        break;
      end
      if (scramble) begin
        cmd_blk_a = {$urandom, $urandom, $urandom, $urandom};
        cmd_blk_b = {$urandom, $urandom, $urandom, $urandom};
        cmd_key   = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
    end
  endtask

  task automatic consume;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    total++; if (round_start !== 1'b0) begin bad++; $display("FAIL reset_round_start got=%b exp=0", round_start); end
    total++; if (round_block_i !== 128'h0) begin bad++; $display("FAIL reset_round_block_i got=%h exp=0", round_block_i); end
    total++; if (round_key !== 128'h0) begin bad++; $display("FAIL reset_round_key got=%h exp=0", round_key); end
    total++; if (res_a !== 128'h0 || res_b !== 128'h0) begin bad++; $display("FAIL reset_res got=%h/%h exp=0/0", res_a, res_b); end
    total++; if (res_valid !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_valid_err got=%b/%b exp=0/0", res_valid, err); end
    reset = 1'b0;
    @(negedge clk);
    $display("reset: outputs at reset values checked");
  endtask

  task automatic test_zero_key;
    logic [127:0] b, exp_b, sa, sb;
    int lat, s1, s2, nst;
    b = 128'h00112233445566778899aabbccddeeff;
    exp_b = aes_round(b, 128'h0);
    start_job(128'h0, b, 128'h0);
    wait_res(1'b0, lat, s1, s2, nst, sa, sb);
    total++; if (lat !== 15) begin bad++; $display("FAIL zk_latency got=%0d exp=15", lat); end
    total++; if (s1 !== 1 || s2 !== 8 || nst !== 2) begin bad++; $display("FAIL zk_starts got=%0d,%0d n=%0d exp=1,8 n=2", s1, s2, nst); end
    total++; if (sb !== b) begin bad++; $display("FAIL zk_block_b got=%h exp=%h", sb, b); end
    total++; if (res_a !== AES_R_ZERO) begin bad++; $display("FAIL zk_res_a got=%h exp=%h", res_a, AES_R_ZERO); end
    total++; if (res_b !== exp_b) begin bad++; $display("FAIL zk_res_b got=%h exp=%h", res_b, exp_b); end
    total++; if (hold_viol !== 0) begin bad++; $display("FAIL zk_hold got=%0d exp=0", hold_viol); end
    consume();
    total++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL zk_idle got=%b/%b exp=1/0", cmd_ready, res_valid); end
    $display("zero_key: lat=%0d starts=%0d,%0d res_b=%h", lat, s1, s2, res_b);
  endtask

  task automatic test_back_pressure;
    logic [127:0] a, b, k, ea, eb, sa, sb;
    int lat, s1, s2, nst;
    a = 128'h0123456789abcdeffedcba9876543210;
    b = 128'hdeadbeef0badf00dcafebabe12345678;
    k = 128'h000102030405060708090a0b0c0d0e0f;
    ea = aes_round(a, k);
    eb = aes_round(b, k);
    start_job(a, b, k);
    wait_res(1'b0, lat, s1, s2, nst, sa, sb);
    total++; if (lat !== 15) begin bad++; $display("FAIL bp_latency got=%0d exp=15", lat); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (res_valid !== 1'b1 || res_a !== ea || res_b !== eb || cmd_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got v=%b rdy=%b a=%h b=%h exp v=1 rdy=0 a=%h b=%h",
                 i, res_valid, cmd_ready, res_a, res_b, ea, eb);
      end
    end
    consume();
    total++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL bp_idle got=%b/%b exp=1/0", cmd_ready, res_valid); end
    $display("back_pressure: held 20 cycles res_a=%h res_b=%h", res_a, res_b);
  endtask

  task automatic test_input_isolation;
    logic [127:0] a, b, k, ea, eb, sa, sb;
    int lat, s1, s2, nst;
    a = 128'h3243f6a8885a308d313198a2e0370734;
    b = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    k = 128'ha0fafe1788542cb123a339392a6c7605;
    ea = aes_round(a, k);
    eb = aes_round(b, k);
    start_job(a, b, k);
    wait_res(1'b1, lat, s1, s2, nst, sa, sb);
    total++; if (res_a !== ea) begin bad++; $display("FAIL iso_res_a got=%h exp=%h", res_a, ea); end
    total++; if (res_b !== eb) begin bad++; $display("FAIL iso_res_b got=%h exp=%h", res_b, eb); end
    total++; if (sa !== a) begin bad++; $display("FAIL iso_block_a got=%h exp=%h", sa, a); end
    consume();
    $display("input_isolation: lat=%0d res_a=%h res_b=%h", lat, res_a, res_b);
  endtask

  task automatic test_back_to_back;
    logic [127:0] a2, b2, k2, sa, sb;
    int lat, s1, s2, nst;
    a2 = 128'h11111111222222223333333344444444;
    b2 = 128'h55555555666666667777777788888888;
    k2 = 128'h0f0e0d0c0b0a09080706050403020100;
    start_job(128'hffeeddccbbaa99887766554433221100, 128'h0, 128'h0);
    wait_res(1'b0, lat, s1, s2, nst, sa, sb);
    res_ready = 1'b1;
    cmd_blk_a = a2; cmd_blk_b = b2; cmd_key = k2; cmd_valid = 1'b1;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_done_accept got=%b exp=0", cmd_ready); end
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b/%b exp=1/0", cmd_ready, res_valid); end
    @(negedge clk);
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    wait_res(1'b0, lat, s1, s2, nst, sa, sb);
    total++; if (lat !== 15) begin bad++; $display("FAIL b2b_latency got=%0d exp=15", lat); end
    total++; if (res_a !== aes_round(a2, k2) || res_b !== aes_round(b2, k2)) begin
      bad++; $display("FAIL b2b_res got=%h/%h exp=%h/%h", res_a, res_b, aes_round(a2, k2), aes_round(b2, k2));
    end
    consume();
    $display("back_to_back: second job lat=%0d res_a=%h", lat, res_a);
  endtask

  task automatic test_busy_core;
    logic [127:0] a, b, sa, sb;
    int lat, s1, s2, nst;
    a = 128'h00000000000000000000000000000001;
    b = 128'h80000000000000000000000000000000;
    force_busy = 1'b1;
    start_job(a, b, 128'h0);
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) @(negedge clk);
      total++;
      if (round_start !== 1'b0 || err !== 1'b0) begin
        bad++; $display("FAIL busy_stall cyc=%0d got start=%b err=%b exp=0/0", i, round_start, err);
      end
    end
    @(negedge clk);
    force_busy = 1'b0;
    #1;
    total++; if (round_start !== 1'b1) begin bad++; $display("FAIL busy_release got=%b exp=1", round_start); end
    wait_res(1'b0, lat, s1, s2, nst, sa, sb);
    total++; if (lat !== 15 || s1 !== 1) begin bad++; $display("FAIL busy_latency got=%0d s1=%0d exp=15 s1=1", lat, s1); end
    total++; if (res_a !== aes_round(a, 128'h0) || res_b !== aes_round(b, 128'h0)) begin
      bad++; $display("FAIL busy_res got=%h/%h exp=%h/%h", res_a, res_b, aes_round(a, 128'h0), aes_round(b, 128'h0));
    end
    consume();
    $display("busy_core: start after stall, lat=%0d err=%b", lat, err);
  endtask

  task automatic test_async_reset;
    logic [127:0] a, b, k, sa, sb;
    int lat, s1, s2, nst;
    a = 128'hcafef00dcafef00dcafef00dcafef00d;
    b = 128'h0102030405060708090a0b0c0d0e0f10;
    k = 128'h13579bdf2468ace013579bdf2468ace0;
    start_job(a, b, k);
    for (int i = 2; i <= 10; i++) @(negedge clk);
    total++; if (round_block_i !== b) begin bad++; $display("FAIL ar_in_wait_b got=%h exp=%h", round_block_i, b); end
    reset = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || err !== 1'b0 || round_start !== 1'b0) begin
      bad++; $display("FAIL ar_ctrl got rdy=%b v=%b err=%b st=%b exp 1/0/0/0", cmd_ready, res_valid, err, round_start);
    end
    total++; if (round_block_i !== 128'h0 || round_key !== 128'h0 || res_a !== 128'h0 || res_b !== 128'h0) begin
      bad++; $display("FAIL ar_data got blk=%h key=%h a=%h b=%h exp all 0", round_block_i, round_key, res_a, res_b);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_job(b, a, k);
    wait_res(1'b0, lat, s1, s2, nst, sa, sb);
    total++; if (lat !== 15) begin bad++; $display("FAIL ar_fresh_latency got=%0d exp=15", lat); end
    total++; if (res_a !== aes_round(b, k) || res_b !== aes_round(a, k)) begin
      bad++; $display("FAIL ar_fresh_res got=%h/%h exp=%h/%h", res_a, res_b, aes_round(b, k), aes_round(a, k));
    end
    consume();
    $display("async_reset: fresh job lat=%0d res_a=%h", lat, res_a);
  endtask

  task automatic test_watchdog;
    hang_mode = 1'b1;
    start_job(128'h1, 128'h2, 128'h0);
    total++; if (round_start !== 1'b1) begin bad++; $display("FAIL wd_start got=%b exp=1", round_start); end
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      total++;
      if (err !== (k >= 17)) begin bad++; $display("FAIL wd_err cyc=%0d got=%b exp=%b", k, err, (k >= 17)); end
    end
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (err !== 1'b1 || cmd_ready !== 1'b0) begin bad++; $display("FAIL wd_sticky cyc=%0d got err=%b rdy=%b exp 1/0", i, err, cmd_ready); end
    end
    cmd_valid = 1'b0;
    hang_mode = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (err !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL wd_clear got err=%b rdy=%b exp 0/1", err, cmd_ready); end
    $display("watchdog: err raised 17 cycles after start, cleared by reset");
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_zero_key();
    test_back_pressure();
    test_input_isolation();
    test_back_to_back();
    test_busy_core();
    test_async_reset();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
